// File: rtl/codif_bin_dec_pkg.sv
// Shared definitions for the binary-to-BCD display converter.
package codif_bin_dec_pkg;

  // Default engine width; also the number of shift iterations per conversion.
  localparam int ANCHO_BIN_DEF = 16;
  // Internal BCD digits: four are displayed, the fifth flags values above 9999.
  localparam int N_DIG_DEF     = 5;
  // Largest value a BCD digit may take; used for saturation.
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CARGA   = 2'd1,
    CONV    = 2'd2,
    PUBLICA = 2'd3
  } estado_t;

endpackage

// File: rtl/codif_bin_dec_if.sv
// Counter-to-display bus: binary value in, four BCD digits and status out.
interface codif_bin_dec_if
  import codif_bin_dec_pkg::*;
#(
  parameter int ANCHO_BIN = ANCHO_BIN_DEF
);

  logic [ANCHO_BIN-1:0] numero;
  logic [3:0]           miles;
  logic [3:0]           centenas;
  logic [3:0]           decenas;
  logic [3:0]           unidades;
  logic                 listo;
  logic                 desbordado;

  // Producer of the count (pulse counter side).
  modport master (
    output numero,
    input  miles, centenas, decenas, unidades, listo, desbordado
  );

  // The converter itself.
  modport slave (
    input  numero,
    output miles, centenas, decenas, unidades, listo, desbordado
  );

endinterface

// File: rtl/codif_bin_dec_ajuste_bcd.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added so that the
// following left shift carries correctly into the next decimal digit.
module ajuste_bcd (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/codif_bin_dec.sv
// Sequential binary-to-BCD converter (shift-add-3) with saturation at 9999.
// A conversion is only started when the input differs from the last value
// converted, so a stable count produces no further activity.
module codif_bin_dec
  import codif_bin_dec_pkg::*;
#(
  parameter int ANCHO_BIN = ANCHO_BIN_DEF,
  parameter int N_DIG     = N_DIG_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  codif_bin_dec_if.slave  bus
);

  localparam int CNT_W = (ANCHO_BIN > 1) ? $clog2(ANCHO_BIN) : 1;
  localparam logic [CNT_W-1:0] ULTIMA_ITER = CNT_W'(ANCHO_BIN - 1);

  estado_t              estado, estado_sig;
  logic                 forzar;
  logic [ANCHO_BIN-1:0] ultimo;
  logic [ANCHO_BIN-1:0] bin_q;
  logic [4*N_DIG-1:0]   bcd_q;
  logic [4*N_DIG-1:0]   bcd_adj;
  logic [CNT_W-1:0]     iter;
  logic                 cargar, desplazar, publicar;
  logic                 exceso;

  logic [3:0] miles_q, centenas_q, decenas_q, unidades_q;
  logic       listo_q, desbordado_q;

  // One correction cell per BCD digit of the accumulator.
  for (genvar g = 0; g < N_DIG; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .d (bcd_q[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // Any nonzero digit above the four displayed ones means the value exceeds 9999.
  assign exceso = |bcd_q[4*N_DIG-1:16];

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers sample their inputs from the same edge, independent of order.
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_sig;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    estado_sig = estado;
    cargar     = 1'b0;
    desplazar  = 1'b0;
    publicar   = 1'b0;
    case (estado)
      IDLE:    if (forzar || (bus.numero != ultimo)) estado_sig = CARGA;
      CARGA: begin
        cargar     = 1'b1;
        estado_sig = CONV;
      end
      CONV: begin
        desplazar = 1'b1;
        if (iter == ULTIMA_ITER) estado_sig = PUBLICA;
      end
      PUBLICA: begin
        publicar   = 1'b1;
        estado_sig = IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  // Last-converted value and the post-reset one-shot conversion request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      forzar <= 1'b1;
      ultimo <= '0;
    end else if (cargar) begin
      forzar <= 1'b0;
      ultimo <= bus.numero;
    end
  end

  // Conversion engine: load, then ANCHO_BIN adjust-and-shift steps.
  always_ff @(posedge clk) begin
    // NOTE: the engine registers carry no reset; CARGA always initialises them
    // before CONV reads them, and the outputs never expose them directly.
    if (cargar) begin
      bin_q <= bus.numero;
      bcd_q <= '0;
      iter  <= '0;
    end else if (desplazar) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      iter           <= iter + 1'b1;
    end
  end

  // Published digits: updated only in PUBLICA, saturating above 9999.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miles_q      <= '0;
      centenas_q   <= '0;
      decenas_q    <= '0;
      unidades_q   <= '0;
      listo_q      <= 1'b0;
      desbordado_q <= 1'b0;
    end else begin
      listo_q <= publicar;
      if (publicar) begin
        if (exceso) begin
          miles_q      <= BCD_MAX;
          centenas_q   <= BCD_MAX;
          decenas_q    <= BCD_MAX;
          unidades_q   <= BCD_MAX;
          desbordado_q <= 1'b1;
        end else begin
          miles_q      <= bcd_q[15:12];
          centenas_q   <= bcd_q[11:8];
          decenas_q    <= bcd_q[7:4];
          unidades_q   <= bcd_q[3:0];
          desbordado_q <= 1'b0;
        end
      end
    end
  end

  assign bus.miles      = miles_q;
  assign bus.centenas   = centenas_q;
  assign bus.decenas    = decenas_q;
  assign bus.unidades   = unidades_q;
  assign bus.listo      = listo_q;
  assign bus.desbordado = desbordado_q;

endmodule

// File: tb/tb_codif_bin_dec.sv
// Bench for codif_bin_dec: directed scenarios plus a random sweep, all checked
// against a decimal-arithmetic model of the displayed value.
module tb_codif_bin_dec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  codif_bin_dec_if bus ();

  codif_bin_dec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected {miles, centenas, decenas, unidades, desbordado} for a count.
  function automatic logic [16:0] modelo(input int unsigned n);
    int unsigned s;
    s = (n > 9999) ? 9999 : n;
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10),
            (n > 9999)};
  endfunction

  function automatic logic [16:0] observado();
    return {bus.miles, bus.centenas, bus.decenas, bus.unidades, bus.desbordado};
  endfunction

  // Waits for listo on falling edges; returns the cycle it was seen, or -1.
  task automatic wait_listo(input int budget, output int ciclos);
    ciclos = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.listo === 1'b1) begin
        ciclos = i;
        return;
      end
    end
  endtask

  // Runs n cycles and counts listo pulses.
  task automatic run_cycles(input int n, output int pulsos);
    pulsos = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.listo === 1'b1) pulsos++;
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.numero = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (observado() !== 17'd0) begin
      $display("FAIL reset_digits got=%h exp=%h", observado(), 17'd0);
      failures++;
    end
    checks++;
    if (bus.listo !== 1'b0) begin
      $display("FAIL reset_listo got=%b exp=0", bus.listo);
      failures++;
    end
  endtask

  task automatic test_hold_99();
    int lat, pulsos;
    bus.numero = 16'd99;
    rst_n      = 1'b1;
    wait_listo(19, lat);
    checks++;
    if (lat != 19) begin
      $display("FAIL hold99_latency got=%0d exp=19", lat);
      failures++;
    end
    checks++;
    if (observado() !== modelo(99)) begin
      $display("FAIL hold99_value got=%h exp=%h", observado(), modelo(99));
      failures++;
    end
    run_cycles(40, pulsos);
    checks++;
    if (pulsos != 0) begin
      $display("FAIL hold99_extra_listo got=%0d exp=0", pulsos);
      failures++;
    end
  endtask

  task automatic test_sequence();
    int unsigned vals [3] = '{500, 16, 100};
    int pulsos;
    foreach (vals[k]) begin
      bus.numero = 16'(vals[k]);
      run_cycles(100, pulsos);
      checks++;
      if (observado() !== modelo(vals[k])) begin
        $display("FAIL seq_value_%0d got=%h exp=%h", vals[k], observado(), modelo(vals[k]));
        failures++;
      end
      checks++;
      if (pulsos != 1) begin
        $display("FAIL seq_listo_%0d got=%0d exp=1", vals[k], pulsos);
        failures++;
      end
    end
  endtask

  task automatic test_boundaries();
    int unsigned vals [4] = '{0, 9999, 10000, 65535};
    int lat;
    foreach (vals[k]) begin
      bus.numero = 16'(vals[k]);
      wait_listo(40, lat);
      checks++;
      if (lat != 19) begin
        $display("FAIL bound_latency_%0d got=%0d exp=19", vals[k], lat);
        failures++;
      end
      checks++;
      if (observado() !== modelo(vals[k])) begin
        $display("FAIL bound_value_%0d got=%h exp=%h", vals[k], observado(), modelo(vals[k]));
        failures++;
      end
    end
  endtask

  task automatic test_change_mid_conv();
    logic [16:0] publicados [$];
    logic [16:0] previo;
    int malos;
    previo     = observado();
    malos      = 0;
    bus.numero = 16'd1234;
    // Edges 1-2 are IDLE and CARGA; edges 3..7 are the first five CONV steps.
    repeat (7) @(negedge clk);
    bus.numero = 16'd4321;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (observado() !== previo && observado() !== modelo(1234) &&
          observado() !== modelo(4321)) malos++;
      if (bus.listo === 1'b1) publicados.push_back(observado());
    end
    checks++;
    if (malos != 0) begin
      $display("FAIL midconv_glitch got=%0d exp=0", malos);
      failures++;
    end
    checks++;
    if (publicados.size() != 2) begin
      $display("FAIL midconv_count got=%0d exp=2", publicados.size());
      failures++;
    end else begin
      checks++;
      if (publicados[0] !== modelo(1234)) begin
        $display("FAIL midconv_first got=%h exp=%h", publicados[0], modelo(1234));
        failures++;
      end
      checks++;
      if (publicados[1] !== modelo(4321)) begin
        $display("FAIL midconv_second got=%h exp=%h", publicados[1], modelo(4321));
        failures++;
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    int lat;
    bus.numero = 16'd777;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (observado() !== 17'd0 || bus.listo !== 1'b0) begin
      $display("FAIL rstconv_clear got=%h/%b exp=%h/0", observado(), bus.listo, 17'd0);
      failures++;
    end
    rst_n = 1'b1;
    wait_listo(40, lat);
    checks++;
    if (lat != 19) begin
      $display("FAIL rstconv_latency got=%0d exp=19", lat);
      failures++;
    end
    checks++;
    if (observado() !== modelo(777)) begin
      $display("FAIL rstconv_value got=%h exp=%h", observado(), modelo(777));
      failures++;
    end
  endtask

  task automatic test_random();
    int unsigned v, previo;
    int lat;
    previo = 777;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 12000);
      else                           v = $urandom_range(0, 65535);
      if (v == previo) v = v ^ 1;
      previo     = v;
      bus.numero = 16'(v);
      wait_listo(40, lat);
      checks++;
      if (lat != 19) begin
        $display("FAIL rand_latency_%0d got=%0d exp=19", v, lat);
        failures++;
      end
      checks++;
      if (observado() !== modelo(v)) begin
        $display("FAIL rand_value_%0d got=%h exp=%h", v, observado(), modelo(v));
        failures++;
      end
    end
  endtask

  initial begin
    bus.numero = 16'd0;
    @(negedge clk);
    test_reset();
    test_hold_99();
    test_sequence();
    test_boundaries();
    test_change_mid_conv();
    test_reset_mid_conv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
